// File: rtl/string_hw_pkg.sv
// string_hw_pkg: shared types and constants for the string accelerator and
// its driver-side software/bench.
//   op_e    : operation select codes carried on the engine's index port
//   state_e : engine FSM state codes
//   ASCII range bounds and the case delta used by the case converter
//   not_found() : FIND "no hit" value for a given MAX_LEN
package string_hw_pkg;

    localparam int CHAR_W = 8;

    localparam logic [CHAR_W-1:0] ASCII_LC_A = 8'h61;
    localparam logic [CHAR_W-1:0] ASCII_LC_Z = 8'h7A;
    localparam logic [CHAR_W-1:0] ASCII_UC_A = 8'h41;
    localparam logic [CHAR_W-1:0] ASCII_UC_Z = 8'h5A;
    localparam logic [CHAR_W-1:0] CASE_DELTA = 8'd32;

    typedef enum logic [2:0] {
        OP_CMP     = 3'd0,
        OP_UPPER   = 3'd1,
        OP_LOWER   = 3'd2,
        OP_FIND    = 3'd3,
        OP_REVERSE = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // FIND reports one past the last legal position when nothing matches.
    function automatic int not_found(input int max_len);
        return max_len;
    endfunction

endpackage

// File: rtl/string_hw_char_unit.sv
// string_hw_char_unit: combinational single-character case converter.
//   ch       in  CHAR_W  character to convert
//   op       in  3       operation select (op_e); only UPPER/LOWER convert
//   conv     out CHAR_W  converted character (pass-through otherwise)
//   is_alpha out 1       ch is an ASCII letter of either case
module string_hw_char_unit
    import string_hw_pkg::*;
(
    input  logic [CHAR_W-1:0] ch,
    input  logic [2:0]        op,
    output logic [CHAR_W-1:0] conv,
    output logic              is_alpha
);

    logic is_lc, is_uc;

    always_comb begin
        is_lc    = (ch >= ASCII_LC_A) && (ch <= ASCII_LC_Z);
        is_uc    = (ch >= ASCII_UC_A) && (ch <= ASCII_UC_Z);
        is_alpha = is_lc || is_uc;
        conv     = ch;
        // Offsets only ever apply inside the letter ranges, so no wrap.
        if (op == OP_UPPER && is_lc)
            conv = ch - CASE_DELTA;
        else if (op == OP_LOWER && is_uc)
            conv = ch + CASE_DELTA;
    end

endmodule

// File: rtl/string_hw_engine.sv
// string_hw_engine: multi-op string accelerator, one character per clock.
// Latches A/B, their lengths and the op on go, runs, then holds results in
// DONE until go drops.
//   clk, reset (async, active low)
//   go, index (op_e), A, B, lengthA, lengthB      request, sampled in IDLE
//   busy (RUN), done (DONE), error                status
//   result, result_len, result_val                results, valid with done
// Optional feature: define STRING_HW_REVERSE_EN to enable op 4 (REVERSE);
// without it op 4 is rejected as illegal and no reverse datapath exists.
module string_hw_engine
    import string_hw_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            go,
    input  logic [2:0]                      index,
    input  logic [0:MAX_LEN-1][CHAR_W-1:0]  A,
    input  logic [0:MAX_LEN-1][CHAR_W-1:0]  B,
    input  logic [LEN_W-1:0]                lengthA,
    input  logic [LEN_W-1:0]                lengthB,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [0:MAX_LEN-1][CHAR_W-1:0]  result,
    output logic [LEN_W-1:0]                result_len,
    output logic [LEN_W-1:0]                result_val
);

    localparam int              IDX_W = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] NF   = LEN_W'(not_found(MAX_LEN));

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_RUN  = S_RUN;
    localparam logic [1:0] ST_DONE = S_DONE;

    logic [1:0]                     state;
    logic [0:MAX_LEN-1][CHAR_W-1:0] a_q, b_q;
    logic [LEN_W-1:0]               la_q, lb_q, i_q;
    logic [2:0]                     op_q;
    logic                           stop_q;   // CMP length mismatch: finish on the next edge

    logic                           cmp_op, find_op, op_ok, bad;
    logic [IDX_W-1:0]               ix;
    logic [CHAR_W-1:0]              a_ch, conv_ch;
    logic                           alpha;

    always_comb begin
        cmp_op  = (op_q == OP_CMP);
        find_op = (op_q == OP_FIND);
`ifdef STRING_HW_REVERSE_EN
        op_ok   = (op_q <= OP_REVERSE);
`else
        op_ok   = (op_q <= OP_FIND);
`endif
        // B only matters to CMP and FIND, so only they can be rejected on lengthB.
        bad     = !op_ok || (la_q > MAXL) || ((cmp_op || find_op) && (lb_q > MAXL));
        // i_q < length <= MAX_LEN whenever a position is processed, so the
        // truncated index is exact.
        ix      = IDX_W'(i_q);
        a_ch    = a_q[ix];
    end

`ifdef STRING_HW_REVERSE_EN
    logic [IDX_W-1:0] rpos;
    assign rpos = IDX_W'(la_q - i_q - LEN_W'(1));
`endif

    string_hw_char_unit u_char (
        .ch       (a_ch),
        .op       (op_q),
        .conv     (conv_ch),
        .is_alpha (alpha)
    );

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            la_q       <= '0;
            lb_q       <= '0;
            op_q       <= '0;
            i_q        <= '0;
            stop_q     <= 1'b0;
            error      <= 1'b0;
            result     <= '0;
            result_len <= '0;
            result_val <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        a_q        <= A;
                        b_q        <= B;
                        la_q       <= lengthA;
                        lb_q       <= lengthB;
                        op_q       <= index;
                        i_q        <= '0;
                        stop_q     <= 1'b0;
                        error      <= 1'b0;
                        result     <= '0;
                        result_len <= '0;
                        result_val <= '0;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bad) begin
                        error <= 1'b1;
                        state <= ST_DONE;
                    end else if (stop_q) begin
                        state <= ST_DONE;
                    end else if (cmp_op && (la_q != lb_q)) begin
                        stop_q <= 1'b1;
                    end else if (i_q == la_q) begin
                        // Every position consumed without an early exit.
                        state <= ST_DONE;
                        if (cmp_op)
                            result_val <= LEN_W'(1);
                        else if (find_op)
                            result_val <= NF;
                        else
                            result_len <= la_q;
                    end else begin
                        i_q <= i_q + LEN_W'(1);
                        if (cmp_op) begin
                            // result_val is already 0, so a mismatch just exits.
                            if (a_ch != b_q[ix])
                                state <= ST_DONE;
                        end else if (find_op) begin
                            if ((lb_q != '0) && (a_ch == b_q[0])) begin
                                result_val <= i_q;
                                state      <= ST_DONE;
                            end
`ifdef STRING_HW_REVERSE_EN
                        end else if (op_q == OP_REVERSE) begin
                            result[rpos] <= a_ch;
`endif
                        end else begin
                            // Only letters are rewritten; everything else passes through.
                            result[ix] <= alpha ? conv_ch : a_ch;
                        end
                    end
                end
                ST_DONE: begin
                    if (!go)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_string_hw_engine.sv
// tb_string_hw_engine: self-checking bench for string_hw_engine.
// Directed cases with hand-derived expectations, randomized requests checked
// against a behavioural model, go-handshake and mid-run reset scenarios.
module tb_string_hw_engine;
    import string_hw_pkg::*;

    localparam int ML = 16;
    localparam int LW = $clog2(ML + 1);
    typedef logic [0:ML-1][7:0] str_t;

    logic          clk = 1'b0;
    logic          reset, go;
    logic [2:0]    index;
    str_t          A, B, result;
    logic [LW-1:0] lengthA, lengthB, result_len, result_val;
    logic          busy, done, error;

    int n_cmp = 0;
    int n_bad = 0;

    string_hw_engine #(.MAX_LEN(ML)) dut (
        .clk(clk), .reset(reset), .go(go), .index(index),
        .A(A), .B(B), .lengthA(lengthA), .lengthB(lengthB),
        .busy(busy), .done(done), .error(error),
        .result(result), .result_len(result_len), .result_val(result_val)
    );

    always #5 clk = ~clk;

    function automatic str_t mk(input string s);
        str_t r = '0;
        for (int i = 0; i < s.len() && i < ML; i++) r[i] = s[i];
        return r;
    endfunction

    // Behavioural model: what the operation should return and how many edges
    // after the go-sampling edge the engine reaches DONE.
    function automatic void model(input logic [2:0] op, input str_t a, input str_t b,
                                  input int la, input int lb,
                                  output str_t r, output int rl, output int rv,
                                  output bit e, output int lat);
        bit legal;
        r = '0; rl = 0; rv = 0; e = 1'b0; lat = 1;
        legal = (op <= 3'd3);
`ifdef STRING_HW_REVERSE_EN
        legal = legal || (op == 3'd4);
`endif
        if (!legal || la > ML || ((op == 3'd0 || op == 3'd3) && lb > ML)) begin
            e = 1'b1;
            return;
        end
        case (op)
            3'd0: begin
                if (la != lb) lat = 2;
                else begin
                    rv = 1; lat = la + 1;
                    for (int i = 0; i < la; i++)
                        if (a[i] != b[i]) begin rv = 0; lat = i + 1; break; end
                end
            end
            3'd1: begin
                rl = la; lat = la + 1;
                for (int i = 0; i < la; i++)
                    r[i] = (a[i] >= 8'h61 && a[i] <= 8'h7A) ? a[i] - 8'd32 : a[i];
            end
            3'd2: begin
                rl = la; lat = la + 1;
                for (int i = 0; i < la; i++)
                    r[i] = (a[i] >= 8'h41 && a[i] <= 8'h5A) ? a[i] + 8'd32 : a[i];
            end
            3'd3: begin
                rv = ML; lat = la + 1;
                if (lb > 0)
                    for (int i = 0; i < la; i++)
                        if (a[i] == b[0]) begin rv = i; lat = i + 1; break; end
            end
            default: begin
                rl = la; lat = la + 1;
                for (int i = 0; i < la; i++) r[la - 1 - i] = a[i];
            end
        endcase
    endfunction

    // Issue one request, scramble the operands after the sampling edge, wait
    // (bounded) for done, and return what the DUT shows. lat = -1 on timeout.
    task automatic run_op(input logic [2:0] op, input str_t a, input str_t b,
                          input int la, input int lb, input bit keep,
                          output str_t r, output int rl, output int rv,
                          output bit e, output int lat);
        @(negedge clk);
        index = op; A = a; B = b; lengthA = LW'(la); lengthB = LW'(lb); go = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < ML; k++) begin A[k] = 8'($urandom); B[k] = 8'($urandom); end
        index = 3'($urandom); lengthA = LW'($urandom); lengthB = LW'($urandom);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin lat = k; break; end
        end
        r = result; rl = int'(result_len); rv = int'(result_val); e = error;
        if (!keep) begin
            @(negedge clk) go = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, done, error} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: busy/done/error=%b required 000", {busy, done, error});
        end
        n_cmp++;
        if (result !== '0) begin
            n_bad++; $display("FAIL reset_result: got %h required 0", result);
        end
        n_cmp++;
        if (result_len !== '0 || result_val !== '0) begin
            n_bad++; $display("FAIL reset_len_val: len=%0d val=%0d required 0/0", result_len, result_val);
        end
    endtask

    task automatic test_directed();
        string nm, sa, sb, sr;
        logic [2:0] op;
        int la, lb, ev, el, et, rl, rv, lat;
        bit ee, e;
        str_t r;
        for (int k = 0; k < 16; k++) begin
            case (k)
                0:  begin nm="cmp_eq";      op=3'd0; sa="abcd"; sb="abcd"; la=4; lb=4; ev=1;  el=0; ee=0; et=5; sr=""; end
                1:  begin nm="cmp_early";   op=3'd0; sa="abXd"; sb="abcd"; la=4; lb=4; ev=0;  el=0; ee=0; et=3; sr=""; end
                2:  begin nm="cmp_lens";    op=3'd0; sa="abc";  sb="abcd"; la=3; lb=4; ev=0;  el=0; ee=0; et=2; sr=""; end
                3:  begin nm="cmp_empty";   op=3'd0; sa="";     sb="";     la=0; lb=0; ev=1;  el=0; ee=0; et=1; sr=""; end
                4:  begin nm="upper";       op=3'd1; sa="aZ9z"; sb="";     la=4; lb=0; ev=0;  el=4; ee=0; et=5; sr="AZ9Z"; end
                5:  begin nm="lower_empty"; op=3'd2; sa="";     sb="";     la=0; lb=0; ev=0;  el=0; ee=0; et=1; sr=""; end
                6:  begin nm="lower_edges"; op=3'd2; sa="Hi@[Z{"; sb="";   la=6; lb=0; ev=0;  el=6; ee=0; et=7; sr="hi@[z{"; end
                7:  begin nm="upper_full";  op=3'd1; sa="a@z{mnopqrstuvwx"; sb=""; la=16; lb=0; ev=0; el=16; ee=0; et=17; sr="A@Z{MNOPQRSTUVWX"; end
                8:  begin nm="find_hit";    op=3'd3; sa="hello"; sb="l";   la=5; lb=1; ev=2;  el=0; ee=0; et=3; sr=""; end
                9:  begin nm="find_miss";   op=3'd3; sa="hello"; sb="q";   la=5; lb=1; ev=16; el=0; ee=0; et=6; sr=""; end
                10: begin nm="find_nob";    op=3'd3; sa="hello"; sb="h";   la=5; lb=0; ev=16; el=0; ee=0; et=6; sr=""; end
                11: begin nm="bad_op";      op=3'd7; sa="abcd"; sb="abcd"; la=4; lb=4; ev=0;  el=0; ee=1; et=1; sr=""; end
                12: begin nm="bad_lena";    op=3'd1; sa="abcd"; sb="";     la=17; lb=0; ev=0; el=0; ee=1; et=1; sr=""; end
                13: begin nm="bad_lenb";    op=3'd0; sa="abc";  sb="abc";  la=3; lb=17; ev=0; el=0; ee=1; et=1; sr=""; end
                14: begin nm="bad_lenb_f";  op=3'd3; sa="abc";  sb="a";    la=3; lb=20; ev=0; el=0; ee=1; et=1; sr=""; end
`ifdef STRING_HW_REVERSE_EN
                default: begin nm="reverse"; op=3'd4; sa="abc"; sb="";     la=3; lb=0; ev=0;  el=3; ee=0; et=4; sr="cba"; end
`else
                default: begin nm="op4_off"; op=3'd4; sa="abc"; sb="";     la=3; lb=0; ev=0;  el=0; ee=1; et=1; sr=""; end
`endif
            endcase
            run_op(op, mk(sa), mk(sb), la, lb, 1'b0, r, rl, rv, e, lat);
            n_cmp++;
            if (lat !== et) begin n_bad++; $display("FAIL %s latency: got %0d required %0d", nm, lat, et); end
            n_cmp++;
            if (e !== ee) begin n_bad++; $display("FAIL %s error: got %0b required %0b", nm, e, ee); end
            n_cmp++;
            if (rv !== ev) begin n_bad++; $display("FAIL %s result_val: got %0d required %0d", nm, rv, ev); end
            n_cmp++;
            if (rl !== el) begin n_bad++; $display("FAIL %s result_len: got %0d required %0d", nm, rl, el); end
            n_cmp++;
            if (r !== mk(sr)) begin n_bad++; $display("FAIL %s result: got %h required %h", nm, r, mk(sr)); end
        end
    endtask

    task automatic test_random();
        logic [7:0] alph [0:11];
        logic [2:0] op;
        str_t a, b, r, er;
        int la, lb, rl, rv, lat, erl, erv, elat, p;
        bit e, ee;
        alph = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B, 8'h30, 8'h6D, 8'h4D, 8'h20};
        for (int t = 0; t < 200; t++) begin
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            la = ($urandom_range(0, 19) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, ML));
            lb = ($urandom_range(0, 19) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, ML));
            for (int k = 0; k < ML; k++) begin
                a[k] = alph[$urandom_range(0, 11)];
                b[k] = alph[$urandom_range(0, 11)];
            end
            if (op == 3'd0 && $urandom_range(0, 1) == 1) begin
                b = a; lb = la;
                if (la > 0 && la <= ML && $urandom_range(0, 1) == 1) begin
                    p = int'($urandom_range(0, la - 1));
                    b[p] = b[p] ^ 8'h01;
                end
            end
            model(op, a, b, la, lb, er, erl, erv, ee, elat);
            run_op(op, a, b, la, lb, 1'b0, r, rl, rv, e, lat);
            n_cmp++;
            if (lat !== elat) begin n_bad++; $display("FAIL rnd%0d op%0d latency: got %0d required %0d", t, op, lat, elat); end
            n_cmp++;
            if (e !== ee) begin n_bad++; $display("FAIL rnd%0d op%0d error: got %0b required %0b", t, op, e, ee); end
            n_cmp++;
            if (rv !== erv) begin n_bad++; $display("FAIL rnd%0d op%0d result_val: got %0d required %0d", t, op, rv, erv); end
            n_cmp++;
            if (rl !== erl) begin n_bad++; $display("FAIL rnd%0d op%0d result_len: got %0d required %0d", t, op, rl, erl); end
            n_cmp++;
            if (r !== er) begin n_bad++; $display("FAIL rnd%0d op%0d result: got %h required %h", t, op, r, er); end
        end
    endtask

    task automatic test_go_held();
        str_t r;
        int rl, rv, lat;
        bit e, held_ok;
        run_op(OP_UPPER, mk("xy"), '0, 2, 0, 1'b1, r, rl, rv, e, lat);
        held_ok = (lat == 3);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            held_ok = held_ok && (done === 1'b1) && (busy === 1'b0) && (result === mk("XY"));
        end
        n_cmp++;
        if (!held_ok) begin
            n_bad++; $display("FAIL go_held: done=%b busy=%b result=%h required 1/0/%h", done, busy, result, mk("XY"));
        end
        @(negedge clk) go = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL go_drop: done=%b busy=%b required 0/0", done, busy);
        end
        run_op(OP_LOWER, mk("QR"), '0, 2, 0, 1'b0, r, rl, rv, e, lat);
        n_cmp++;
        if (r !== mk("qr") || lat !== 3 || rl !== 2) begin
            n_bad++; $display("FAIL go_reissue: result=%h lat=%0d len=%0d required %h/3/2", r, lat, rl, mk("qr"));
        end
    endtask

    task automatic test_reset_mid_run();
        str_t r, er;
        int rl, rv, lat, erl, erv, elat;
        bit e, ee;
        @(negedge clk);
        index = OP_UPPER; A = mk("abcdefgh"); B = '0; lengthA = LW'(8); lengthB = '0; go = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL midrun_busy: got %b required 1", busy); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, error} !== 3'b000 || result !== '0 || result_len !== '0 || result_val !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset: flags=%b result=%h len=%0d val=%0d required all 0",
                     {busy, done, error}, result, result_len, result_val);
        end
        go = 1'b0;
        @(negedge clk) reset = 1'b1;
        model(OP_FIND, mk("abcabc"), mk("c"), 6, 1, er, erl, erv, ee, elat);
        run_op(OP_FIND, mk("abcabc"), mk("c"), 6, 1, 1'b0, r, rl, rv, e, lat);
        n_cmp++;
        if (rv !== erv || lat !== elat || e !== ee) begin
            n_bad++; $display("FAIL after_reset: val=%0d lat=%0d err=%0b required %0d/%0d/%0b", rv, lat, e, erv, elat, ee);
        end
    endtask

    initial begin
        reset = 1'b0; go = 1'b0; index = '0; A = '0; B = '0; lengthA = '0; lengthB = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) reset = 1'b1;
        test_directed();
        test_random();
        test_go_held();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
